tick_pwm: RTL and testbench
===========================

# tick_pwm

Pulse-width modulator that sits directly downstream of the clock divider. It consumes the divider's slow square-wave output as an asynchronous-level input `tick_in` and synchronises it into the `clk_in` domain. Each rising edge of `tick_in` advances a PWM period counter one step. The duty value is loaded through a valid/ready handshake, held in a shadow register, and applied only at period boundaries, so the output never glitches.

## Interface
- `NBITS`, 8: width of the period counter and the duty value.
- `PERIOD`, 100: steps per PWM period; legal range 2..2^NBITS.
- `SYNC_STAGES`, 2: flops in the `tick_in` synchroniser; minimum 2.
- `clk_in`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the `clk_in` rising edge.
- `tick_in`  in  1  divided clock from the divider; asynchronous to `clk_in`.
- `enable`  in  1  high = run, low = idle.
- `duty_in`  in  NBITS  requested high-time, in steps.
- `duty_valid`  in  1  `duty_in` is valid.
- `duty_ready`  out  1  shadow register free; update accepted on `duty_valid & duty_ready`.
- `pwm_out`  out  1  registered PWM output.
- `period_start`  out  1  one-cycle strobe at the start of each period.
- `step_out`  out  1  one-cycle registered strobe per detected `tick_in` rising edge.
- `cnt_out`  out  NBITS  current period counter value.

## Operation
- **Reset** (`reset`=0 at a clock edge):
  - Synchroniser flops, edge-history flop, counter, active duty and shadow duty clear to 0.
  - Pending flag clears.
  - Output values: `pwm_out`=0, `period_start`=0, `step_out`=0, `cnt_out`=0, `duty_ready`=1.
  - Reset mid-operation discards any pending duty update.
- **Synchroniser:**
  - `tick_in` passes through `SYNC_STAGES` flops.
  - An internal `step` is asserted when the last stage is 1 and the history flop is 0.
  - A `tick_in` held high through reset therefore yields exactly one step after reset releases.
- **States:** IDLE and RUN. IDLE while `enable`=0; RUN while `enable`=1.
- **IDLE behaviour:**
  - Counter held at 0; `pwm_out`=0; steps ignored, but the synchroniser keeps tracking.
  - A pending shadow value is copied to active duty immediately and the pending flag clears.
- **IDLE->RUN:** `period_start` pulses in the first cycle with `enable`=1; counter starts at 0.
- **RUN->IDLE:** `pwm_out` and counter forced to 0 at the next edge.
- **Counting in RUN:**
  - On `step`, counter increments.
  - If counter = PERIOD-1, it wraps to 0 instead. Compare against PERIOD-1 computed at NBITS width; PERIOD=2^NBITS wraps naturally.
  - On wrap, `period_start` pulses and, if pending, active duty is loaded from shadow and the pending flag clears.
- **Output compare:** `pwm_out` is registered as (counter < active duty), unsigned.
  - Duty 0 gives a constant low output.
  - Duty >= PERIOD gives a constant high output. No saturation is applied; the compare handles it.
- **Duty handshake:**
  - `duty_ready` = NOT pending.
  - On accept, shadow is loaded with `duty_in` and pending sets.
  - An accept in the same cycle as a wrap does not load active duty; the new value applies at the next wrap.
  - `duty_valid` while `duty_ready`=0 is ignored; the value is not queued.

## Timing
- Let edge k be the first `clk_in` edge that samples `tick_in`=1.
  - Internal `step` is high in the cycle after edge k+SYNC_STAGES-1.
  - `step_out` and `cnt_out` update at edge k+SYNC_STAGES.
  - `pwm_out` reflects the new count at edge k+SYNC_STAGES+1.
- `period_start` is asserted in the same cycle that `cnt_out` shows 0 after a wrap.
- `duty_ready` drops at the edge after accept and rises at the edge that performs the wrap.
- Minimum `tick_in` high and low times: SYNC_STAGES+1 `clk_in` periods each. Shorter pulses may be missed; this is not an error.

## Test plan
- **Reset:** assert reset 3 cycles with `tick_in`=1 -> all outputs at reset values; exactly one `step_out` pulse 3 cycles after release (SYNC_STAGES=2).
- **Basic PWM:** PERIOD=10, duty 3 accepted in IDLE, `enable`=1, `tick_in` with period 8 `clk_in` -> `pwm_out` high for 3 steps, low for 7; `period_start` each time `cnt_out` goes from 9 to 0.
- **Shadow update:** in RUN at `cnt_out`=4 with duty 3, send duty 7 -> `duty_ready` low; waveform unchanged until wrap; then 7 high / 3 low; `duty_ready` back to 1 at wrap.
- **Handshake:**
  - Second `duty_valid` (duty 1) while pending -> ignored; duty 7 is the value applied.
  - Accept at the wrap cycle -> value applied one period later.
- **Extremes:**
  - duty 0 -> `pwm_out` constant 0.
  - duty 10 and duty 255 -> constant 1.
  - NBITS=8, PERIOD=256 -> counter wraps 255 to 0.
- **Enable and mid-run reset:**
  - Drop `enable` at `cnt_out`=5 -> `cnt_out`=0 and `pwm_out`=0 next edge.
  - Re-enable -> `period_start` pulse.
  - Synchronous reset mid-period with pending update -> pending discarded, active duty 0.

Source files
------------

// File: rtl/tick_pwm.sv
// tick_pwm: PWM generator advanced by the rising edges of a slow, asynchronous tick.
//
// The divided clock on tick_in is synchronised into clk_in, edge-detected, and each
// detected rising edge advances a period counter by one step. A new duty value is
// taken through a valid/ready handshake into a shadow register and only becomes the
// active duty at a period boundary (or at once while idle), so pwm_out never glitches.
//
// Parameters:
//   NBITS       width of the period counter and of the duty value
//   PERIOD      steps per PWM period, 2..2**NBITS
//   SYNC_STAGES flops in the tick_in synchroniser, at least 2
//
// Ports:
//   clk_in        system clock, all state updates on its rising edge
//   reset         synchronous active-low reset
//   tick_in       divided clock, asynchronous to clk_in
//   enable        1 = run, 0 = idle
//   duty_in       requested high time in steps
//   duty_valid    duty_in is valid
//   duty_ready    shadow register free; update accepted on duty_valid & duty_ready
//   pwm_out       registered PWM output
//   period_start  one-cycle strobe at the start of each period
//   step_out      one-cycle strobe per detected tick_in rising edge
//   cnt_out       current period counter value

module tick_pwm #(
    parameter int unsigned NBITS       = 8,
    parameter int unsigned PERIOD      = 100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             enable,
    input  logic [NBITS-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             step_out,
    output logic [NBITS-1:0] cnt_out
);

    // Last count of a period. Truncated to NBITS so that PERIOD = 2**NBITS gives
    // the all-ones value and the counter wraps through its natural overflow point.
    localparam logic [NBITS-1:0] LAST_CNT = NBITS'(PERIOD - 1);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    // ------------------------------------------------------------------------
    // tick_in synchroniser and rising-edge detector
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   step;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // History clears in reset, so a tick_in held high through reset still produces
    // exactly one step once the synchroniser fills after release.
    assign step = sync_q[SYNC_STAGES-1] & ~hist_q;

    // ------------------------------------------------------------------------
    // Control and datapath state
    // ------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] duty_act_q, duty_act_d;
    logic [NBITS-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;
    logic             ps_q, ps_d;
    logic             step_out_q, step_out_d;
    logic             accept;

    // The shadow register only takes a value while nothing is pending; a valid
    // presented while busy is simply dropped.
    assign accept = duty_valid & ~pending_q;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            duty_act_q <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            pwm_q      <= 1'b0;
            ps_q       <= 1'b0;
            step_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            duty_act_q <= duty_act_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            pwm_q      <= pwm_d;
            ps_q       <= ps_d;
            step_out_q <= step_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        duty_act_d = duty_act_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        pwm_d      = 1'b0;
        ps_d       = 1'b0;
        step_out_d = step;

        // Accept and the pending-to-active transfers below never coincide: accept
        // needs pending clear, the transfers need it set. An accept on a wrap edge
        // therefore waits for the following wrap.
        if (accept) begin
            shadow_d  = duty_in;
            pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Nothing is being generated, so a pending duty can go live at once.
                if (pending_q) begin
                    duty_act_d = shadow_q;
                    pending_d  = 1'b0;
                end
                if (enable) begin
                    state_d = StRun;
                    // Strobe lands in the first RUN cycle, alongside cnt_out = 0,
                    // matching the timing of a wrap strobe.
                    ps_d    = 1'b1;
                end
            end

            StRun: begin
                if (!enable) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    // Unsigned compare: duty 0 stays low, duty >= PERIOD stays high.
                    pwm_d = (cnt_q < duty_act_q);
                    if (step) begin
                        if (cnt_q == LAST_CNT) begin
                            cnt_d = '0;
                            ps_d  = 1'b1;
                            if (pending_q) begin
                                duty_act_d = shadow_q;
                                pending_d  = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_q + NBITS'(1);
                        end
                    end
                end
            end
        endcase
    end

    assign duty_ready   = ~pending_q;
    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign step_out     = step_out_q;
    assign cnt_out      = cnt_q;

endmodule

// File: tb/tb_tick_pwm.sv
// Testbench for tick_pwm: table of duty values with expected per-count waveform masks,
// plus hand-written sequences for reset, shadow updates, handshake corners, enable
// toggling, mid-run reset and the full-width 256-step period.

module tb_tick_pwm;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       tick_in;
    logic       enable;
    logic       enable256;
    logic [7:0] duty_in;
    logic       duty_valid;

    logic       duty_ready, pwm_out, period_start, step_out;
    logic [7:0] cnt_out;
    logic       duty_ready256, pwm256, ps256, step256;
    logic [7:0] cnt256;

    always #5 clk_in = ~clk_in;

    tick_pwm #(.NBITS(8), .PERIOD(10), .SYNC_STAGES(2)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .tick_in      (tick_in),
        .enable       (enable),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .step_out     (step_out),
        .cnt_out      (cnt_out)
    );

    tick_pwm #(.NBITS(8), .PERIOD(256), .SYNC_STAGES(2)) dut256 (
        .clk_in       (clk_in),
        .reset        (reset),
        .tick_in      (tick_in),
        .enable       (enable256),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready256),
        .pwm_out      (pwm256),
        .period_start (ps256),
        .step_out     (step256),
        .cnt_out      (cnt256)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Strobe monitors, sampled on the falling edge.
    int ps_n = 0, ps_bad = 0, step_n = 0, ps256_n = 0;
    always @(negedge clk_in) begin
        if (period_start) begin
            ps_n <= ps_n + 1;
            if (cnt_out != 8'd0) ps_bad <= ps_bad + 1;
        end
        if (step_out) step_n <= step_n + 1;
        if (ps256) ps256_n <= ps256_n + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // One tick_in period: 4 cycles high, 4 low. The counter moves 3 edges after the
    // rise and pwm_out follows one edge later, so both are settled on return.
    task automatic step_once();
        tick_in = 1'b1;
        repeat (4) cyc();
        tick_in = 1'b0;
        repeat (4) cyc();
    endtask

    // Sample pwm_out at counts first..first+n-1 into a mask, stepping after each.
    task automatic run_span(input int first, input int n, output logic [9:0] m);
        m = '0;
        for (int i = 0; i < n; i++) begin
            m[first+i] = pwm_out;
            step_once();
        end
    endtask

    // Load a duty while idle: accepted on the first edge, made active on the second.
    task automatic load_idle(input logic [7:0] d);
        enable     = 1'b0;
        duty_in    = d;
        duty_valid = 1'b1;
        cyc();
        duty_valid = 1'b0;
        cyc();
    endtask

    typedef struct {
        logic [7:0] duty;
        logic [9:0] mask;  // bit i = expected pwm_out while cnt_out == i
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [9:0] m, m2;
        int         seen, at, base_ps, base_step;

        vecs[0] = '{duty: 8'd3,   mask: 10'b00_0000_0111};
        vecs[1] = '{duty: 8'd0,   mask: 10'b00_0000_0000};
        vecs[2] = '{duty: 8'd10,  mask: 10'b11_1111_1111};
        vecs[3] = '{duty: 8'd255, mask: 10'b11_1111_1111};
        vecs[4] = '{duty: 8'd1,   mask: 10'b00_0000_0001};
        vecs[5] = '{duty: 8'd9,   mask: 10'b01_1111_1111};
        vecs[6] = '{duty: 8'd7,   mask: 10'b00_0111_1111};

        // ---- Reset with tick_in held high ----
        reset      = 1'b0;
        tick_in    = 1'b1;
        enable     = 1'b0;
        enable256  = 1'b0;
        duty_in    = 8'd0;
        duty_valid = 1'b0;
        repeat (3) cyc();
        check("rst pwm_out", pwm_out, 0);
        check("rst period_start", period_start, 0);
        check("rst step_out", step_out, 0);
        check("rst cnt_out", cnt_out, 0);
        check("rst duty_ready", duty_ready, 1);
        reset = 1'b1;
        seen  = 0;
        at    = -1;
        for (int j = 1; j <= 10; j++) begin
            cyc();
            if (step_out) begin
                seen++;
                at = j;
            end
        end
        check("rst step count", seen, 1);
        check("rst step cycle", at, 3);
        tick_in = 1'b0;
        repeat (4) cyc();

        // ---- Table: full period per duty value ----
        for (int v = 0; v < 7; v++) begin
            load_idle(vecs[v].duty);
            check($sformatf("vec%0d ready", v), duty_ready, 1);
            enable = 1'b1;
            cyc();
            check($sformatf("vec%0d entry strobe", v), period_start, 1);
            cyc();
            base_ps   = ps_n;
            base_step = step_n;
            run_span(0, 10, m);
            check($sformatf("vec%0d duty %0d mask", v, vecs[v].duty), m, vecs[v].mask);
            check($sformatf("vec%0d cnt after wrap", v), cnt_out, 0);
            check($sformatf("vec%0d wrap strobes", v), ps_n - base_ps, 1);
            check($sformatf("vec%0d step strobes", v), step_n - base_step, 10);
            enable = 1'b0;
            cyc();
        end

        // ---- Shadow update mid-period, second request while pending ignored ----
        load_idle(8'd3);
        enable = 1'b1;
        cyc();
        cyc();
        run_span(0, 4, m);
        check("shadow cnt at 4", cnt_out, 4);
        duty_in    = 8'd7;
        duty_valid = 1'b1;
        cyc();
        duty_valid = 1'b0;
        check("shadow ready low", duty_ready, 0);
        duty_in    = 8'd1;
        duty_valid = 1'b1;
        cyc();
        duty_valid = 1'b0;
        check("busy ready still low", duty_ready, 0);
        run_span(4, 6, m2);
        check("shadow old waveform", m | m2, 10'b00_0000_0111);
        check("shadow ready after wrap", duty_ready, 1);
        check("shadow cnt after wrap", cnt_out, 0);
        run_span(0, 10, m);
        check("shadow new waveform", m, 10'b00_0111_1111);

        // ---- Accept on the wrap edge: applied one period later ----
        run_span(0, 9, m);
        check("pre-wrap waveform", m, 10'b00_0111_1111);
        tick_in = 1'b1;
        cyc();
        cyc();
        duty_in    = 8'd5;
        duty_valid = 1'b1;
        cyc();
        duty_valid = 1'b0;
        check("wrap-accept strobe", period_start, 1);
        check("wrap-accept cnt", cnt_out, 0);
        check("wrap-accept ready", duty_ready, 0);
        cyc();
        tick_in = 1'b0;
        repeat (4) cyc();
        run_span(0, 10, m);
        check("wrap-accept held period", m, 10'b00_0111_1111);
        check("wrap-accept ready later", duty_ready, 1);
        run_span(0, 10, m);
        check("wrap-accept applied", m, 10'b00_0001_1111);

        // ---- Drop enable at cnt 5, then re-enable ----
        load_idle(8'd9);
        enable = 1'b1;
        cyc();
        cyc();
        run_span(0, 5, m);
        check("en cnt at 5", cnt_out, 5);
        check("en pwm high at 5", pwm_out, 1);
        enable = 1'b0;
        cyc();
        check("disable cnt", cnt_out, 0);
        check("disable pwm", pwm_out, 0);
        enable = 1'b1;
        cyc();
        check("reenable strobe", period_start, 1);
        check("reenable cnt", cnt_out, 0);
        cyc();

        // ---- Synchronous reset mid-period with a pending update ----
        run_span(0, 3, m);
        duty_in    = 8'd8;
        duty_valid = 1'b1;
        cyc();
        duty_valid = 1'b0;
        check("midrst ready before", duty_ready, 0);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("midrst ready", duty_ready, 1);
        check("midrst cnt", cnt_out, 0);
        check("midrst pwm", pwm_out, 0);
        cyc();
        check("midrst entry strobe", period_start, 1);
        cyc();
        run_span(0, 10, m);
        check("midrst duty cleared", m, 10'b00_0000_0000);

        // ---- Full-width counter wraps 255 -> 0 ----
        enable    = 1'b0;
        enable256 = 1'b1;
        cyc();
        cyc();
        base_ps = ps256_n;
        repeat (255) step_once();
        check("p256 cnt at 255", cnt256, 255);
        step_once();
        check("p256 cnt wrapped", cnt256, 0);
        check("p256 wrap strobe", ps256_n - base_ps, 1);

        check("strobes at count 0", ps_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
